mem_wb_stage: RTL
=================

Name: mem_wb_stage

Overview:
- Memory/write-back end of the pipeline: accepts executed instructions and performs data-memory loads and stores over a req/ack handshake.
- Returns the register-file write (enable, address, data) to the decode block's register file, closing the WB-to-decode path.
- Asserts a pipeline stall while a memory access is outstanding.
- Sits after the execute stage; its write-back outputs feed the decode block's reg_file_write_en_i / reg_data_i inputs.

Parameters:
- TIMEOUT_CYCLES, 16, max ACCESS cycles without dmem_ack_i before abort (>=2)
- DATA_W, WORD (32), data/address width
- RADDR_W, ADDR_WIDTH (4), register address width

Ports:
- clk_i  in  1  clock
- reset_i  in  1  async active-low reset
- valid_i  in  1  EXE presents an instruction this cycle
- alu_result_i  in  DATA_W  ALU result / memory address
- store_data_i  in  DATA_W  store data
- reg_dest_addr_i  in  RADDR_W  destination register
- reg_file_write_en_i  in  reg_file_write_sig  instruction writes the register file
- reg_file_input_ctrl_sig_i  in  reg_file_data_source  write-back source, ALU or MEM
- mem_write_en_i  in  mem_write_signal  store
- mem_read_en_i  in  mem_read_signal  load
- dmem_req_o  out  1  memory request
- dmem_we_o  out  1  1=write
- dmem_addr_o  out  DATA_W  word address
- dmem_wdata_o  out  DATA_W  store data
- dmem_ack_i  in  1  access complete; rdata valid this cycle
- dmem_rdata_i  in  DATA_W  load data
- stall_o  out  stall_pipeline_sig  hold upstream stages
- reg_file_write_en_o  out  1  register-file write strobe, to decode
- reg_dest_addr_o  out  RADDR_W  write address, to decode
- reg_data_o  out  DATA_W  write data, to decode
- bus_error_o  out  1  sticky error flag

Behaviour:
- Interface: one clock, clk_i; reset_i is asynchronous and active-low.
- Reset values:
  - state=IDLE.
  - All dmem_* outputs 0.
  - stall_o=no-stall.
  - reg_file_write_en_o=0, reg_dest_addr_o=0, reg_data_o=0.
  - bus_error_o=0, timeout counter=0.
- Reset mid-ACCESS: dmem_req_o drops asynchronously; the in-flight instruction is discarded with no write-back.
- FSM states: IDLE, ACCESS.
- IDLE, valid_i with no memory op:
  - Next cycle, reg_file_write_en_o = (reg_file_write_en_i == enabled).
  - reg_data_o = alu_result_i; reg_dest_addr_o = reg_dest_addr_i.
  - Latency 1; no stall.
- IDLE, valid_i with exactly one of read/write:
  - If alu_result_i[1:0] != 0: set bus_error_o, no access, no write-back, stay IDLE.
  - Otherwise, next cycle: state=ACCESS, dmem_req_o=1, dmem_we_o=write, dmem_addr_o=alu_result_i, dmem_wdata_o=store_data_i.
  - Capture dest address, write enable and source.
- IDLE, valid_i with both read and write: set bus_error_o, no access, no write-back.
- ACCESS:
  - stall_o=stall every ACCESS cycle, including the ack cycle.
  - dmem_req/we/addr/wdata held stable through the ack cycle inclusive.
  - Counter increments each ACCESS cycle.
- ACCESS with dmem_ack_i:
  - Next cycle: state=IDLE, dmem_req_o=0, counter=0.
  - Load: reg_file_write_en_o=captured enable, reg_data_o=dmem_rdata_i sampled in the ack cycle.
  - Store: reg_file_write_en_o=0 regardless of the enable.
- ACCESS, no ack, counter reaches TIMEOUT_CYCLES-1: abort.
  - Next cycle: state=IDLE, dmem_req_o=0, bus_error_o=1, no write-back.
  - If ack arrives in the same cycle, ack wins and no error is raised.
- Load with source=ALU: writes alu_result_i instead of load data (decode guarantees this never occurs; the behaviour is defined anyway).
- valid_i is ignored while in ACCESS; upstream holds it under stall and it is accepted in the first IDLE cycle.
- reg_file_write_en_o pulses exactly one cycle per retired writing instruction; otherwise 0.
- reg_data_o and reg_dest_addr_o hold their last values when the strobe is low.
- bus_error_o is sticky until reset.

Decomposition:
- Shared package: DATA_W/WORD, ADDR_WIDTH, existing reg_file_write_sig, reg_file_data_source, mem_read_signal, mem_write_signal, stall_pipeline_sig.
- New package entry: typedef enum mem_wb_state {MW_IDLE, MW_ACCESS}.
- One natural sub-module: dmem_access_fsm (FSM, timeout counter, dmem_* registers, stall). Write-back mux and output registers stay in the top.

Test Plan:
- ALU op, valid_i=1, alu_result_i=0x1234, dest=3, write enabled -> next cycle reg_file_write_en_o=1, reg_dest_addr_o=3, reg_data_o=0x1234; stall never asserted.
- Load from address 0x40, dest=5, ack on the 3rd ACCESS cycle with rdata=0xDEADBEEF -> dmem_req_o high 3 cycles at addr 0x40, we=0; stall_o for those 3 cycles; cycle after ack write-back r5=0xDEADBEEF; back-to-back ALU op accepted the following cycle.
- Store 0xCAFEF00D to 0x80, write_en asserted, 1-cycle ack -> dmem_we_o=1, wdata=0xCAFEF00D; no reg_file_write_en_o pulse.
- Load to 0x42 (misaligned) -> dmem_req_o never rises, bus_error_o=1 next cycle, no write-back.
- Load, ack never arrives, TIMEOUT_CYCLES=16 -> req high 16 cycles then drops, bus_error_o=1, no write-back.
- Ack on cycle 16 -> normal completion, no error.
- reset_i low during ACCESS cycle 2 -> dmem_req_o and stall drop immediately; no write-back after release; next load proceeds normally.

Source files
------------

// File: rtl/mem_wb_pkg.sv
// mem_wb_pkg
// Shared pipeline types and widths for the memory / write-back stage.
//   WORD, ADDR_WIDTH      : data/address width and register address width
//   reg_file_write_sig    : register-file write enable
//   reg_file_data_source  : write-back source (ALU result or memory data)
//   mem_read_signal       : load request from decode/execute
//   mem_write_signal      : store request from decode/execute
//   stall_pipeline_sig    : upstream hold
//   mem_wb_state          : state of the data-memory access FSM
package mem_wb_pkg;

   localparam int WORD       = 32;
   localparam int ADDR_WIDTH = 4;

   typedef enum logic {REG_WRITE_DISABLE = 1'b0, REG_WRITE_ENABLE = 1'b1} reg_file_write_sig;
   typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1}                     reg_file_data_source;
   typedef enum logic {MEM_READ_DISABLE = 1'b0, MEM_READ_ENABLE = 1'b1}   mem_read_signal;
   typedef enum logic {MEM_WRITE_DISABLE = 1'b0, MEM_WRITE_ENABLE = 1'b1} mem_write_signal;
   typedef enum logic {NO_STALL = 1'b0, STALL = 1'b1}                     stall_pipeline_sig;

   typedef enum logic {MW_IDLE = 1'b0, MW_ACCESS = 1'b1} mem_wb_state;

   // Word accesses only: the two byte-offset bits must be zero.
   function automatic logic is_word_aligned(input logic [1:0] i_lsb);
      return (i_lsb == 2'b00);
   endfunction

endpackage

// File: rtl/mem_wb_stage_dmem_access_fsm.sv
// dmem_access_fsm
// Runs one data-memory access over the req/ack handshake, with a timeout.
// Handshake: o_req rises the cycle after i_start and, together with o_we,
// o_addr and o_wdata, stays stable up to and including the cycle in which
// i_ack is high; the access completes in that ack cycle and o_req drops on
// the next edge. Without an ack the access is aborted after TIMEOUT_CYCLES
// ACCESS cycles; an ack in the last allowed cycle still completes normally.
// Ports:
//   i_clk, i_rst_n           : clock, asynchronous active-low reset
//   i_start                  : begin an access (only honoured in IDLE)
//   i_we, i_addr, i_wdata    : access direction, word address, store data
//   i_ack                    : memory completed the access this cycle
//   o_req, o_we, o_addr, o_wdata : registered memory request
//   o_stall                  : high for every ACCESS cycle
//   o_done                   : ACCESS cycle with ack (completion this cycle)
//   o_timeout                : ACCESS cycle in which the access is aborted
//   o_state                  : current FSM state (debug/observation)
module dmem_access_fsm
   import mem_wb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int DATA_W         = WORD
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic              i_we,
   input  logic [DATA_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_ack,
   output logic              o_req,
   output logic              o_we,
   output logic [DATA_W-1:0] o_addr,
   output logic [DATA_W-1:0] o_wdata,
   output stall_pipeline_sig o_stall,
   output logic              o_done,
   output logic              o_timeout,
   output mem_wb_state       o_state
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   mem_wb_state      r_state;
   mem_wb_state      w_next_state;
   logic [CNT_W-1:0] r_cnt;
   logic             w_done;
   logic             w_timeout;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= MW_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Ack has priority over the timeout in the last allowed cycle.
   always_comb begin
      w_next_state = r_state;
      w_done       = 1'b0;
      w_timeout    = 1'b0;
      case (r_state)
         MW_IDLE: begin
            if (i_start) begin
               w_next_state = MW_ACCESS;
            end
         end
         MW_ACCESS: begin
            if (i_ack) begin
               w_done       = 1'b1;
               w_next_state = MW_IDLE;
            end else if (r_cnt == CNT_LAST) begin
               w_timeout    = 1'b1;
               w_next_state = MW_IDLE;
            end
         end
         default: w_next_state = MW_IDLE;
      endcase
   end

   // Counter holds the number of ACCESS cycles already spent without ack.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if ((r_state == MW_ACCESS) && (w_next_state == MW_ACCESS)) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end else begin
         r_cnt <= '0;
      end
   end

   // Address and write data stay at their last values after the access;
   // only req/we are cleared so nothing looks like a live request.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_req   <= 1'b0;
         o_we    <= 1'b0;
         o_addr  <= '0;
         o_wdata <= '0;
      end else if ((r_state == MW_IDLE) && i_start) begin
         o_req   <= 1'b1;
         o_we    <= i_we;
         o_addr  <= i_addr;
         o_wdata <= i_wdata;
      end else if (w_done || w_timeout) begin
         o_req   <= 1'b0;
         o_we    <= 1'b0;
      end
   end

   assign o_stall   = (r_state == MW_ACCESS) ? STALL : NO_STALL;
   assign o_done    = w_done;
   assign o_timeout = w_timeout;
   assign o_state   = r_state;

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage
// Memory / write-back end of the pipeline. ALU instructions retire one cycle
// after acceptance; loads and stores go through dmem_access_fsm and retire
// the cycle after ack. Misaligned accesses, simultaneous read+write and
// timeouts set the sticky bus_error_o and produce no write-back.
// Ports:
//   clk_i, reset_i                       : clock, async active-low reset
//   valid_i, alu_result_i, store_data_i  : instruction from execute
//   reg_dest_addr_i, reg_file_write_en_i : destination register and enable
//   reg_file_input_ctrl_sig_i            : write-back source (ALU/MEM)
//   mem_write_en_i, mem_read_en_i        : store / load
//   dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o : memory request
//   dmem_ack_i, dmem_rdata_i             : memory completion and load data
//   stall_o                              : hold upstream while accessing
//   reg_file_write_en_o, reg_dest_addr_o, reg_data_o : write-back to decode
//   bus_error_o                          : sticky error flag
module mem_wb_stage
   import mem_wb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int DATA_W         = WORD,
   parameter int RADDR_W        = ADDR_WIDTH
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                valid_i,
   input  logic [DATA_W-1:0]   alu_result_i,
   input  logic [DATA_W-1:0]   store_data_i,
   input  logic [RADDR_W-1:0]  reg_dest_addr_i,
   input  reg_file_write_sig   reg_file_write_en_i,
   input  reg_file_data_source reg_file_input_ctrl_sig_i,
   input  mem_write_signal     mem_write_en_i,
   input  mem_read_signal      mem_read_en_i,
   output logic                dmem_req_o,
   output logic                dmem_we_o,
   output logic [DATA_W-1:0]   dmem_addr_o,
   output logic [DATA_W-1:0]   dmem_wdata_o,
   input  logic                dmem_ack_i,
   input  logic [DATA_W-1:0]   dmem_rdata_i,
   output stall_pipeline_sig   stall_o,
   output logic                reg_file_write_en_o,
   output logic [RADDR_W-1:0]  reg_dest_addr_o,
   output logic [DATA_W-1:0]   reg_data_o,
   output logic                bus_error_o
);

   logic                w_rd;
   logic                w_wr;
   logic                w_mem_op;
   logic                w_aligned;
   logic                w_accept;
   logic                w_start;
   logic                w_err_set;
   logic                w_done;
   logic                w_timeout;
   logic                w_wen_alu;
   logic                w_wen_mem;
   mem_wb_state         w_fsm_state;

   logic [RADDR_W-1:0]  r_cap_dest;
   logic                r_cap_we;
   logic                r_cap_load;
   reg_file_data_source r_cap_src;

   assign w_rd      = (mem_read_en_i == MEM_READ_ENABLE);
   assign w_wr      = (mem_write_en_i == MEM_WRITE_ENABLE);
   assign w_mem_op  = w_rd | w_wr;
   assign w_aligned = is_word_aligned(alu_result_i[1:0]);

   // valid_i is only looked at while the access FSM is idle.
   assign w_accept  = valid_i && (w_fsm_state == MW_IDLE);
   assign w_start   = w_accept && (w_rd ^ w_wr) && w_aligned;
   assign w_err_set = (w_accept && w_mem_op && ((w_rd && w_wr) || !w_aligned)) || w_timeout;

   assign w_wen_alu = w_accept && !w_mem_op && (reg_file_write_en_i == REG_WRITE_ENABLE);
   assign w_wen_mem = w_done && r_cap_load && r_cap_we;

   dmem_access_fsm #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .DATA_W         (DATA_W)
   ) u_dmem_access_fsm (
      .i_clk     (clk_i),
      .i_rst_n   (reset_i),
      .i_start   (w_start),
      .i_we      (w_wr),
      .i_addr    (alu_result_i),
      .i_wdata   (store_data_i),
      .i_ack     (dmem_ack_i),
      .o_req     (dmem_req_o),
      .o_we      (dmem_we_o),
      .o_addr    (dmem_addr_o),
      .o_wdata   (dmem_wdata_o),
      .o_stall   (stall_o),
      .o_done    (w_done),
      .o_timeout (w_timeout),
      .o_state   (w_fsm_state)
   );

   // Context of the in-flight memory instruction.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_cap_dest <= '0;
         r_cap_we   <= 1'b0;
         r_cap_load <= 1'b0;
         r_cap_src  <= SRC_ALU;
      end else if (w_start) begin
         r_cap_dest <= reg_dest_addr_i;
         r_cap_we   <= (reg_file_write_en_i == REG_WRITE_ENABLE);
         r_cap_load <= w_rd;
         r_cap_src  <= reg_file_input_ctrl_sig_i;
      end
   end

   // Write-back registers. Data/address only change when the strobe fires.
   // For a load sourced from the ALU, the captured address (dmem_addr_o) is
   // the ALU result of that instruction.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         reg_file_write_en_o <= 1'b0;
         reg_dest_addr_o     <= '0;
         reg_data_o          <= '0;
      end else begin
         reg_file_write_en_o <= w_wen_alu | w_wen_mem;
         if (w_wen_alu) begin
            reg_dest_addr_o <= reg_dest_addr_i;
            reg_data_o      <= alu_result_i;
         end else if (w_wen_mem) begin
            reg_dest_addr_o <= r_cap_dest;
            reg_data_o      <= (r_cap_src == SRC_MEM) ? dmem_rdata_i : dmem_addr_o;
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         bus_error_o <= 1'b0;
      end else if (w_err_set) begin
         bus_error_o <= 1'b1;
      end
   end

endmodule
